// File: rtl/prbs8_checker_if.sv
// Bit-stream and status bundle between a PRBS source/bench and prbs8_checker.
interface prbs8_checker_if #(
    parameter int CNT_W = 16
);
    logic             Din;
    logic             DinValid;
    logic             Clear;
    logic             Locked;
    logic             ErrPulse;
    logic [CNT_W-1:0] ErrCount;
    logic [CNT_W-1:0] BitCount;
    logic             LockLost;

    modport master (
        output Din, DinValid, Clear,
        input  Locked, ErrPulse, ErrCount, BitCount, LockLost
    );

    modport slave (
        input  Din, DinValid, Clear,
        output Locked, ErrPulse, ErrCount, BitCount, LockLost
    );
endinterface

// File: rtl/prbs8_checker.sv
// Self-seeding checker for the 8-bit PRBS (taps 7,6,3,0): lock tracking, error
// pulses and saturating error/bit counters.
//
// state | meaning
// SEED  | loading 8 received bits into sr; no checking
// CHECK | predicting each bit from sr and counting mismatches
module prbs8_checker #(
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic           Clk,
    input  logic           RST,
    prbs8_checker_if.slave bus
);
    typedef enum logic {SEED = 1'b0, CHECK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       THRESH  = 4'(LOSS_THRESH);

    state_t           state, state_n;
    logic [7:0]       sr, sr_n;
    logic [2:0]       seed_cnt, seed_cnt_n;
    logic [3:0]       consec, consec_n;
    logic [CNT_W-1:0] err_cnt, err_cnt_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic             err_pulse, err_pulse_n;
    logic             lock_lost, lock_lost_n;
    logic             exp_bit, mismatch, inc_err, inc_bit;

    assign exp_bit = sr[7] ^ sr[6] ^ sr[3] ^ sr[0];

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state     <= SEED;
            sr        <= 8'h00;
            seed_cnt  <= 3'd0;
            consec    <= 4'd0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            seed_cnt  <= seed_cnt_n;
            consec    <= consec_n;
            err_cnt   <= err_cnt_n;
            bit_cnt   <= bit_cnt_n;
            err_pulse <= err_pulse_n;
            lock_lost <= lock_lost_n;
        end
    end

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        seed_cnt_n  = seed_cnt;
        consec_n    = consec;
        err_pulse_n = 1'b0;
        lock_lost_n = 1'b0;
        inc_err     = 1'b0;
        inc_bit     = 1'b0;
        mismatch    = 1'b0;
        if (bus.DinValid) begin
            case (state)
                SEED: begin
                    sr_n       = {sr[6:0], bus.Din};
                    seed_cnt_n = seed_cnt + 3'd1;
                    if (seed_cnt == 3'd7) begin
                        seed_cnt_n = 3'd0;
                        // an all-zero seed would lock the predictor up, so reseed
                        if (sr_n != 8'h00) begin
                            state_n  = CHECK;
                            consec_n = 4'd0;
                        end
                    end
                end
                CHECK: begin
                    mismatch = (bus.Din != exp_bit);
                    sr_n     = {sr[6:0], exp_bit};
                    inc_bit  = 1'b1;
                    if (mismatch) begin
                        err_pulse_n = 1'b1;
                        inc_err     = 1'b1;
                        consec_n    = consec + 4'd1;
                        if (consec_n == THRESH) begin
                            state_n     = SEED;
                            lock_lost_n = 1'b1;
                            seed_cnt_n  = 3'd0;
                            consec_n    = 4'd0;
                        end
                    end else begin
                        consec_n = 4'd0;
                    end
                end
                default: state_n = SEED;
            endcase
        end
    end

    // Clear wins over a coincident increment
    always_comb begin
        err_cnt_n = err_cnt;
        bit_cnt_n = bit_cnt;
        if (bus.Clear) begin
            err_cnt_n = '0;
            bit_cnt_n = '0;
        end else begin
            if (inc_err && err_cnt != CNT_MAX) err_cnt_n = err_cnt + CNT_ONE;
            if (inc_bit && bit_cnt != CNT_MAX) bit_cnt_n = bit_cnt + CNT_ONE;
        end
    end

    assign bus.Locked   = (state == CHECK);
    assign bus.ErrPulse = err_pulse;
    assign bus.LockLost = lock_lost;
    assign bus.ErrCount = err_cnt;
    assign bus.BitCount = bit_cnt;
endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: a 16-bit and a 4-bit counter instance
// share one stimulus stream and are compared against a behavioural model.
module tb_prbs8_checker;
    localparam int LOSS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clear = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    prbs8_checker_if #(.CNT_W(16)) if16 ();
    prbs8_checker_if #(.CNT_W(4))  if4 ();

    assign if16.Din = din;
    assign if16.DinValid = din_valid;
    assign if16.Clear = clear;
    assign if4.Din = din;
    assign if4.DinValid = din_valid;
    assign if4.Clear = clear;

    prbs8_checker #(.CNT_W(16), .LOSS_THRESH(LOSS)) dut16 (.Clk(clk), .RST(rst), .bus(if16));
    prbs8_checker #(.CNT_W(4),  .LOSS_THRESH(LOSS)) dut4  (.Clk(clk), .RST(rst), .bus(if4));

    always #5 clk = ~clk;

    typedef struct {
        logic locked;
        logic pulse;
        logic lost;
        int   err16;
        int   bit16;
        int   err4;
        int   bit4;
    } exp_t;

    exp_t exp_q[$];

    // behavioural reference model
    logic       m_locked, m_pulse, m_lost;
    logic [7:0] m_sr;
    int         m_seed, m_consec, m_err16, m_bit16, m_err4, m_bit4;

    // generator side
    logic [7:0] gen_sr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, want);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_pulse = 1'b0; m_lost = 1'b0;
        m_sr = 8'h00; m_seed = 0; m_consec = 0;
        m_err16 = 0; m_bit16 = 0; m_err4 = 0; m_bit4 = 0;
    endtask

    task automatic model_step(input logic d, input logic v, input logic c);
        logic e;
        bit inc_e, inc_b;
        inc_e = 0; inc_b = 0;
        m_pulse = 1'b0; m_lost = 1'b0;
        if (v) begin
            if (!m_locked) begin
                m_sr = {m_sr[6:0], d};
                if (m_seed == 7) begin
                    m_seed = 0;
                    if (m_sr != 8'h00) begin
                        m_locked = 1'b1;
                        m_consec = 0;
                    end
                end else begin
                    m_seed++;
                end
            end else begin
                e = ^(m_sr & 8'hC9);
                m_sr = {m_sr[6:0], e};
                inc_b = 1;
                if (d != e) begin
                    m_pulse = 1'b1;
                    inc_e = 1;
                    m_consec++;
                    if (m_consec == LOSS) begin
                        m_locked = 1'b0;
                        m_lost = 1'b1;
                        m_seed = 0;
                        m_consec = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (c) begin
            m_err16 = 0; m_bit16 = 0; m_err4 = 0; m_bit4 = 0;
        end else begin
            if (inc_e && m_err16 < 65535) m_err16++;
            if (inc_b && m_bit16 < 65535) m_bit16++;
            if (inc_e && m_err4 < 15) m_err4++;
            if (inc_b && m_bit4 < 15) m_bit4++;
        end
    endtask

    task automatic step(input logic d, input logic v, input logic c);
        exp_t x;
        @(negedge clk);
        din = d; din_valid = v; clear = c;
        model_step(d, v, c);
        x.locked = m_locked; x.pulse = m_pulse; x.lost = m_lost;
        x.err16 = m_err16; x.bit16 = m_bit16; x.err4 = m_err4; x.bit4 = m_bit4;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("locked16", 32'(if16.Locked), 32'(x.locked));
        chk("pulse16", 32'(if16.ErrPulse), 32'(x.pulse));
        chk("lost16", 32'(if16.LockLost), 32'(x.lost));
        chk("errcnt16", 32'(if16.ErrCount), x.err16);
        chk("bitcnt16", 32'(if16.BitCount), x.bit16);
        chk("locked4", 32'(if4.Locked), 32'(x.locked));
        chk("pulse4", 32'(if4.ErrPulse), 32'(x.pulse));
        chk("lost4", 32'(if4.LockLost), 32'(x.lost));
        chk("errcnt4", 32'(if4.ErrCount), x.err4);
        chk("bitcnt4", 32'(if4.BitCount), x.bit4);
    endtask

    task automatic idle();
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic send(input logic flip, input logic clr);
        logic b;
        b = gen_sr[7] ^ gen_sr[6] ^ gen_sr[3] ^ gen_sr[0];
        gen_sr = {gen_sr[6:0], b};
        step(b ^ flip, 1'b1, clr);
    endtask

    task automatic seed_gen(input logic [7:0] s, input bit gaps);
        gen_sr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            gen_sr = {gen_sr[6:0], s[i]};
            step(s[i], 1'b1, 1'b0);
            if (gaps) idle();
        end
    endtask

    // async reset applied between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst = 1'b1;
        din_valid = 1'b0;
        clear = 1'b0;
        model_reset();
        #1;
        chk("rst_locked", 32'(if16.Locked) | 32'(if4.Locked), 0);
        chk("rst_pulse", 32'(if16.ErrPulse) | 32'(if4.ErrPulse), 0);
        chk("rst_lost", 32'(if16.LockLost) | 32'(if4.LockLost), 0);
        chk("rst_errcnt", 32'(if16.ErrCount) | 32'(if4.ErrCount), 0);
        chk("rst_bitcnt", 32'(if16.BitCount) | 32'(if4.BitCount), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] first_bits;
        first_bits = 6'b011100;
        model_reset();
        do_reset();

        // clean stream from seed 8'h40, then the known first six bits
        seed_gen(8'h40, 0);
        chk("lock_after_seed", 32'(if16.Locked), 1);
        for (int i = 0; i < 6; i++) begin
            gen_sr = {gen_sr[6:0], first_bits[i]};
            step(first_bits[i], 1'b1, 1'b0);
        end
        for (int i = 0; i < 994; i++) send(1'b0, 1'b0);
        chk("clean_errcnt", 32'(if16.ErrCount), 0);
        chk("clean_bitcnt", 32'(if16.BitCount), 1000);
        chk("clean_bitcnt_sat4", 32'(if4.BitCount), 15);

        // single flipped bit: one pulse, no propagation
        send(1'b1, 1'b0);
        chk("single_pulse", 32'(if16.ErrPulse), 1);
        chk("single_errcnt", 32'(if16.ErrCount), 1);
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        chk("single_no_prop", 32'(if16.ErrCount), 1);
        chk("single_locked", 32'(if16.Locked), 1);

        // four consecutive errors drop lock; reseed from clean bits
        send(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
        chk("loss_errcnt", 32'(if16.ErrCount), 4);
        chk("loss_pulse", 32'(if16.LockLost), 1);
        chk("loss_unlocked", 32'(if16.Locked), 0);
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        chk("relock", 32'(if16.Locked), 1);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
        chk("relock_errcnt", 32'(if16.ErrCount), 4);

        // all-zero seed is rejected
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        chk("zero_seed_unlocked", 32'(if16.Locked), 0);
        seed_gen(8'h40, 0);
        chk("zero_seed_relock", 32'(if16.Locked), 1);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
        chk("zero_seed_errcnt", 32'(if16.ErrCount), 0);

        // gapped valid gives the same result as continuous
        do_reset();
        seed_gen(8'h40, 1);
        chk("gap_lock", 32'(if16.Locked), 1);
        for (int i = 0; i < 1000; i++) begin
            send(1'b0, 1'b0);
            idle();
        end
        chk("gap_bitcnt", 32'(if16.BitCount), 1000);
        chk("gap_errcnt", 32'(if16.ErrCount), 0);

        // saturation of the narrow counter, then Clear vs error
        send(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
        end
        chk("sat_errcnt4", 32'(if4.ErrCount), 15);
        chk("sat_errcnt16", 32'(if16.ErrCount), 20);
        chk("sat_locked", 32'(if4.Locked), 1);
        send(1'b1, 1'b1);
        chk("clr_errcnt", 32'(if16.ErrCount), 0);
        chk("clr_pulse", 32'(if4.ErrPulse), 1);

        // async reset mid-CHECK
        do_reset();
        seed_gen(8'h40, 0);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
